nand_flash_ctrl: RTL and testbench

NAND_FLASH_CTRL -- requirements
Module: nand_flash_ctrl

---
 rtl/nand_flash_ctrl.sv | 149 ++++++++++++++
 tb/tb_nand_flash_ctrl.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/nand_flash_ctrl.sv
// Command/response controller for a simple NAND-style memory: read, program with
// verify readback, and full erase, each with a fixed busy-wait.
module nand_flash_ctrl #(
  parameter int unsigned PROG_CYCLES  = 4,
  parameter int unsigned ERASE_CYCLES = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [1:0] cmd_op,
  input  logic [7:0] cmd_addr,
  input  logic [7:0] cmd_wdata,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic [7:0] rsp_rdata,
  output logic       rsp_err,
  output logic       mem_we,
  output logic       mem_re,
  output logic       mem_erase,
  output logic [7:0] mem_addr,
  output logic [7:0] mem_din,
  input  logic [7:0] mem_dout
);

  typedef enum logic [3:0] {
    StIdle,
    StRdIssue,
    StRdCapt,
    StPgIssue,
    StPgWait,
    StVfIssue,
    StVfCapt,
    StErIssue,
    StErWait,
    StResp
  } state_e;

  localparam logic [1:0] OpRead  = 2'b00;
  localparam logic [1:0] OpProg  = 2'b01;
  localparam logic [1:0] OpErase = 2'b10;

  state_e     state_q;
  logic [7:0] cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      cnt_q     <= 8'h00;
      cmd_ready <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_rdata <= 8'h00;
      rsp_err   <= 1'b0;
      mem_we    <= 1'b0;
      mem_re    <= 1'b0;
      mem_erase <= 1'b0;
      mem_addr  <= 8'h00;
      mem_din   <= 8'h00;
    end else begin
      // Strobes are single-cycle pulses; only the issuing transition raises one.
      mem_we    <= 1'b0;
      mem_re    <= 1'b0;
      mem_erase <= 1'b0;
      case (state_q)
        StIdle: begin
          if (cmd_valid) begin
            cmd_ready <= 1'b0;
            mem_addr  <= cmd_addr;
            mem_din   <= cmd_wdata;
            case (cmd_op)
              OpRead: begin
                state_q <= StRdIssue;
                mem_re  <= 1'b1;
              end
              OpProg: begin
                state_q <= StPgIssue;
                mem_we  <= 1'b1;
              end
              OpErase: begin
                state_q   <= StErIssue;
                mem_erase <= 1'b1;
              end
              default: begin
                state_q   <= StResp;
                rsp_valid <= 1'b1;
                rsp_rdata <= 8'h00;
                rsp_err   <= 1'b1;
              end
            endcase
          end
        end
        StRdIssue: state_q <= StRdCapt;
        StRdCapt: begin
          state_q   <= StResp;
          rsp_valid <= 1'b1;
          rsp_rdata <= mem_dout;
          rsp_err   <= 1'b0;
        end
        StPgIssue: begin
          state_q <= StPgWait;
          cnt_q   <= 8'(PROG_CYCLES - 1);
        end
        StPgWait: begin
          if (cnt_q == 8'h00) begin
            state_q <= StVfIssue;
            mem_re  <= 1'b1;
          end else begin
            cnt_q <= cnt_q - 8'h01;
          end
        end
        StVfIssue: state_q <= StVfCapt;
        StVfCapt: begin
          state_q   <= StResp;
          rsp_valid <= 1'b1;
          rsp_rdata <= mem_dout;
          rsp_err   <= (mem_dout != mem_din);
        end
        StErIssue: begin
          state_q <= StErWait;
          cnt_q   <= 8'(ERASE_CYCLES - 1);
        end
        StErWait: begin
          if (cnt_q == 8'h00) begin
            state_q   <= StResp;
            rsp_valid <= 1'b1;
            rsp_rdata <= 8'h00;
            rsp_err   <= 1'b0;
          end else begin
            cnt_q <= cnt_q - 8'h01;
          end
        end
        StResp: begin
          if (rsp_ready) begin
            state_q   <= StIdle;
            cmd_ready <= 1'b1;
            rsp_valid <= 1'b0;
            rsp_rdata <= 8'h00;
            rsp_err   <= 1'b0;
          end
        end
        default: begin
          state_q   <= StIdle;
          cmd_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_nand_flash_ctrl.sv
// Directed bench for nand_flash_ctrl with a behavioural 256-byte memory attached.
module tb_nand_flash_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [1:0] cmd_op = 2'b00;
  logic [7:0] cmd_addr = 8'h00;
  logic [7:0] cmd_wdata = 8'h00;
  logic       rsp_valid;
  logic       rsp_ready = 1'b0;
  logic [7:0] rsp_rdata;
  logic       rsp_err;
  logic       mem_we;
  logic       mem_re;
  logic       mem_erase;
  logic [7:0] mem_addr;
  logic [7:0] mem_din;
  logic [7:0] mem_dout;

  int checks = 0;
  int failures = 0;

  nand_flash_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_addr  (cmd_addr),
    .cmd_wdata (cmd_wdata),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err),
    .mem_we    (mem_we),
    .mem_re    (mem_re),
    .mem_erase (mem_erase),
    .mem_addr  (mem_addr),
    .mem_din   (mem_din),
    .mem_dout  (mem_dout)
  );

  always #5 clk = ~clk;

  // Memory model: registered read, erase clears to 00, optional corrupt readback.
  logic [7:0] mem [256];
  logic [7:0] dout_q = 8'h00;
  logic       mem_init = 1'b0;
  logic       force_cc = 1'b0;
  assign mem_dout = force_cc ? 8'hCC : dout_q;

  always @(posedge clk) begin
    if (!mem_init) begin
      for (int i = 0; i < 256; i++) mem[i] <= 8'h5A;
      mem_init <= 1'b1;
    end else begin
      if (mem_we) mem[mem_addr] <= mem_din;
      if (mem_erase) for (int i = 0; i < 256; i++) mem[i] <= 8'h00;
      if (mem_re) dout_q <= mem[mem_addr];
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Issue one command, then watch cycles T+1.. until rsp_valid (bounded).
  task automatic run_cmd(input logic [1:0] op, input logic [7:0] addr, input logic [7:0] wdata,
                         output int lat, output int n_we, output int n_re, output int n_er,
                         output logic [7:0] rdata, output logic err);
    int multi;
    int bad_addr;
    bit seen;
    lat = 0; n_we = 0; n_re = 0; n_er = 0; multi = 0; bad_addr = 0; seen = 0;
    rdata = 8'h00; err = 1'b0;
    @(negedge clk);
    check_eq("accept_ready", 32'(cmd_ready), 32'd1);
    cmd_valid = 1'b1; cmd_op = op; cmd_addr = addr; cmd_wdata = wdata;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    for (int k = 1; k <= 64 && !seen; k++) begin
      @(negedge clk);
      n_we += int'(mem_we);
      n_re += int'(mem_re);
      n_er += int'(mem_erase);
      if (int'(mem_we) + int'(mem_re) + int'(mem_erase) > 1) multi++;
      if ((mem_we || mem_re) && mem_addr !== addr) bad_addr++;
      if (rsp_valid) begin
        seen = 1; lat = k; rdata = rsp_rdata; err = rsp_err;
      end
    end
    check_eq("rsp_seen", 32'(seen), 32'd1);
    check_eq("strobe_overlap", 32'(multi), 32'd0);
    check_eq("strobe_addr", 32'(bad_addr), 32'd0);
  endtask

  task automatic take_rsp();
    rsp_ready = 1'b1;
    @(posedge clk);
    #1 rsp_ready = 1'b0;
    @(negedge clk);
    check_eq("rsp_cleared", 32'(rsp_valid), 32'd0);
    check_eq("ready_again", 32'(cmd_ready), 32'd1);
  endtask

  task automatic do_cmd(input string name, input logic [1:0] op, input logic [7:0] addr,
                        input logic [7:0] wdata, input int e_lat, input int e_we, input int e_re,
                        input int e_er, input logic [7:0] e_rdata, input logic e_err);
    int lat, n_we, n_re, n_er;
    logic [7:0] rdata;
    logic err;
    run_cmd(op, addr, wdata, lat, n_we, n_re, n_er, rdata, err);
    check_eq({name, "_lat"}, 32'(lat), 32'(e_lat));
    check_eq({name, "_we"}, 32'(n_we), 32'(e_we));
    check_eq({name, "_re"}, 32'(n_re), 32'(e_re));
    check_eq({name, "_erase"}, 32'(n_er), 32'(e_er));
    check_eq({name, "_rdata"}, 32'(rdata), 32'(e_rdata));
    check_eq({name, "_err"}, 32'(err), 32'(e_err));
    take_rsp();
  endtask

  initial begin
    int lat, n_we, n_re, n_er, n_rv;
    logic [7:0] rdata;
    logic err;

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_eq("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    check_eq("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check_eq("rst_rsp_err", 32'(rsp_err), 32'd0);
    check_eq("rst_rsp_rdata", 32'(rsp_rdata), 32'd0);
    check_eq("rst_strobes", 32'({mem_we, mem_re, mem_erase}), 32'd0);
    check_eq("rst_mem_addr", 32'(mem_addr), 32'd0);
    check_eq("rst_mem_din", 32'(mem_din), 32'd0);

    do_cmd("prog01", 2'b01, 8'h01, 8'hAB, 8, 1, 1, 0, 8'hAB, 1'b0);
    do_cmd("read01", 2'b00, 8'h01, 8'h00, 3, 0, 1, 0, 8'hAB, 1'b0);
    do_cmd("prog02", 2'b01, 8'h02, 8'hCD, 8, 1, 1, 0, 8'hCD, 1'b0);
    force_cc = 1'b1;
    do_cmd("prog02_bad", 2'b01, 8'h02, 8'hCD, 8, 1, 1, 0, 8'hCC, 1'b1);
    force_cc = 1'b0;

    // Hold the response for 5 cycles; a program command offered meanwhile must be ignored.
    run_cmd(2'b00, 8'h01, 8'h00, lat, n_we, n_re, n_er, rdata, err);
    check_eq("bp_first_rdata", 32'(rdata), 32'hAB);
    n_we = 0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      @(negedge clk);
      check_eq("bp_rsp_valid", 32'(rsp_valid), 32'd1);
      check_eq("bp_rsp_rdata", 32'(rsp_rdata), 32'hAB);
      check_eq("bp_rsp_err", 32'(rsp_err), 32'd0);
      check_eq("bp_cmd_ready", 32'(cmd_ready), 32'd0);
      n_we += int'(mem_we);
      if (i == 1) begin
        cmd_valid = 1'b1; cmd_op = 2'b01; cmd_addr = 8'h05; cmd_wdata = 8'h11;
      end
      if (i == 2) cmd_valid = 1'b0;
    end
    check_eq("bp_no_we", 32'(n_we), 32'd0);
    take_rsp();
    do_cmd("read05", 2'b00, 8'h05, 8'h00, 3, 0, 1, 0, 8'h5A, 1'b0);

    do_cmd("erase", 2'b10, 8'h00, 8'h00, 18, 0, 0, 1, 8'h00, 1'b0);
    do_cmd("read01_er", 2'b00, 8'h01, 8'h00, 3, 0, 1, 0, 8'h00, 1'b0);
    do_cmd("read02_er", 2'b00, 8'h02, 8'h00, 3, 0, 1, 0, 8'h00, 1'b0);
    do_cmd("reserved", 2'b11, 8'h07, 8'h33, 1, 0, 0, 0, 8'h00, 1'b1);

    // Reset during PG_WAIT: abort, reset values next cycle, no verify read, no response.
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = 2'b01; cmd_addr = 8'h03; cmd_wdata = 8'h77;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_eq("abort_cmd_ready", 32'(cmd_ready), 32'd1);
    check_eq("abort_rsp_valid", 32'(rsp_valid), 32'd0);
    check_eq("abort_strobes", 32'({mem_we, mem_re, mem_erase}), 32'd0);
    check_eq("abort_mem_addr", 32'(mem_addr), 32'd0);
    check_eq("abort_mem_din", 32'(mem_din), 32'd0);
    n_rv = 0; n_re = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      n_rv += int'(rsp_valid);
      n_re += int'(mem_re);
    end
    check_eq("abort_no_rsp", 32'(n_rv), 32'd0);
    check_eq("abort_no_re", 32'(n_re), 32'd0);
    do_cmd("read03", 2'b00, 8'h03, 8'h00, 3, 0, 1, 0, 8'h77, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
